control_sequencer: RTL

- Multi-cycle fetch/decode/execute FSM for the Sim-AC 8-bit accumulator CPU.
- Sits directly upstream of the branch unit. It latches the instruction register and drives the opcode and jump-qualify strobe that the branch unit consumes.
- Also drives the control strobes for the PC, MAR, memory, accumulator, ALU and flags register.
- The branch unit, not this block, decides whether a jump is taken.

---
 rtl/control_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/decode/execute FSM for the Sim-AC 8-bit accumulator CPU.
// Holds the instruction register and drives the branch-unit opcode and
// jump-qualify strobe, plus the PC/MAR/memory/accumulator/ALU/flags strobes.
// Optional build macro: SINGLE_STEP_EN adds step_i. When it is defined,
// fetch waits in F_ADDR until step_i is sampled high.
module control_sequencer #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH+2:0] instr_i,
  input  logic                  mem_ready_i,
`ifdef SINGLE_STEP_EN
  input  logic                  step_i,
`endif
  output logic [2:0]            op_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  ctrl_jmp_o,
  output logic                  ctrl_mar_pc_o,
  output logic                  ctrl_mar_ir_o,
  output logic                  ctrl_mem_rd_o,
  output logic                  ctrl_mem_wr_o,
  output logic                  ctrl_ir_we_o,
  output logic                  ctrl_pc_inc_o,
  output logic                  ctrl_a_we_o,
  output logic                  ctrl_alu_add_o,
  output logic                  ctrl_flags_we_o,
  output logic                  halted_o
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_F_ADDR = 3'd1,
    S_F_READ = 3'd2,
    S_DECODE = 3'd3,
    S_X_ADDR = 3'd4,
    S_X_MEM  = 3'd5,
    S_X_JMP  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_LDA = 3'b010,
    OP_STA = 3'b011,
    OP_JMP = 3'b100,
    OP_JZ  = 3'b101,
    OP_JC  = 3'b110,
    OP_HLT = 3'b111
  } opcode_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH+2:0] ir_q;
  opcode_t               opcode;

  assign op_o   = ir_q[ADDR_WIDTH+2:ADDR_WIDTH];
  assign addr_o = ir_q[ADDR_WIDTH-1:0];
  assign opcode = opcode_t'(ir_q[ADDR_WIDTH+2:ADDR_WIDTH]);

  // State register and IR; IR loads on the completing fetch-read cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_RESET;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (ctrl_ir_we_o) begin
        ir_q <= instr_i;
      end
    end
  end

  // Next-state and strobe decode. Memory-completion strobes also depend on mem_ready_i.
  always_comb begin
    state_d         = state_q;
    ctrl_jmp_o      = 1'b0;
    ctrl_mar_pc_o   = 1'b0;
    ctrl_mar_ir_o   = 1'b0;
    ctrl_mem_rd_o   = 1'b0;
    ctrl_mem_wr_o   = 1'b0;
    ctrl_ir_we_o    = 1'b0;
    ctrl_pc_inc_o   = 1'b0;
    ctrl_a_we_o     = 1'b0;
    ctrl_alu_add_o  = 1'b0;
    ctrl_flags_we_o = 1'b0;
    halted_o        = 1'b0;
    case (state_q)
      S_RESET: state_d = S_F_ADDR;
      S_F_ADDR: begin
`ifdef SINGLE_STEP_EN
        if (step_i) begin
          ctrl_mar_pc_o = 1'b1;
          state_d       = S_F_READ;
        end
`else
        ctrl_mar_pc_o = 1'b1;
        state_d       = S_F_READ;
`endif
      end
      S_F_READ: begin
        ctrl_mem_rd_o = 1'b1;
        if (mem_ready_i) begin
          ctrl_ir_we_o  = 1'b1;
          ctrl_pc_inc_o = 1'b1;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP:                state_d = S_F_ADDR;
          OP_ADD, OP_LDA, OP_STA: state_d = S_X_ADDR;
          OP_JMP, OP_JZ, OP_JC:  state_d = S_X_JMP;
          default:               state_d = S_HALT;
        endcase
      end
      S_X_ADDR: begin
        ctrl_mar_ir_o = 1'b1;
        state_d       = S_X_MEM;
      end
      S_X_MEM: begin
        ctrl_mem_rd_o = (opcode == OP_LDA) || (opcode == OP_ADD);
        ctrl_mem_wr_o = (opcode == OP_STA);
        if (mem_ready_i) begin
          ctrl_a_we_o     = (opcode == OP_LDA) || (opcode == OP_ADD);
          ctrl_alu_add_o  = (opcode == OP_ADD);
          ctrl_flags_we_o = (opcode == OP_ADD);
          state_d         = S_F_ADDR;
        end
      end
      S_X_JMP: begin
        ctrl_jmp_o = 1'b1;
        state_d    = S_F_ADDR;
      end
      S_HALT: halted_o = 1'b1;
      default: state_d = S_RESET;
    endcase
  end

endmodule
